conv_encoder: RTL

Rate-1/2, constraint-length-3 convolutional encoder with generators (7,5) octal. It is the transmit-side counterpart of the Viterbi decoder and produces exactly the trellis codewords the decoder's branch-metric unit expects. It accepts one DATA_W-bit frame per handshake, serialises it MSB first, and encodes each bit into a 2-bit codeword. It then appends K-1 = 2 zero tail bits so every frame terminates in S0, and streams the codewords out under valid/ready flow control.

---
 rtl/conv_encoder_pkg.sv | 17 +
 rtl/conv_enc_core.sv | 18 +
 rtl/conv_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/conv_encoder_pkg.sv
// Shared constants and types for the rate-1/2, K=3 (7,5) convolutional code.
// The Viterbi side's models use the same generators and codeword type.
package conv_encoder_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G1 = 3'b111;
  localparam logic [K-1:0] G0 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_e;

  typedef logic [1:0] code_t;

endpackage

// File: rtl/conv_enc_core.sv
// One trellis step: input bit u and state {m1,m2} give the codeword {c1,c0}
// and the successor state {u,m1}. Purely combinational.
module conv_enc_core
  import conv_encoder_pkg::*;
(
  input  logic       u_i,
  input  logic [1:0] st_i,
  output logic [1:0] code_o,
  output logic [1:0] next_st_o
);

  logic [K-1:0] taps;

  assign taps      = {u_i, st_i};
  assign code_o    = {^(taps & G1), ^(taps & G0)};
  assign next_st_o = {u_i, st_i[1]};

endmodule

// File: rtl/conv_encoder.sv
// Frame-based (7,5) convolutional encoder: serialises a DATA_W-bit payload MSB
// first, appends two zero tail bits, and streams codewords under valid/ready.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [1:0]        code_o,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic              sof_o,
  output logic              eof_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fsm_e              fsm_q, fsm_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        st_q, st_d;

  logic  u;
  code_t core_code;
  logic [1:0] core_nst;
  logic  busy;
  logic  xfer;

  // Everything visible on the output side depends on registers only.
  assign busy = (fsm_q == DATA) || (fsm_q == TAIL);
  assign u    = (fsm_q == DATA) ? sreg_q[DATA_W-1] : 1'b0;
  assign xfer = busy && code_ready_i;

  conv_enc_core u_core (
    .u_i      (u),
    .st_i     (st_q),
    .code_o   (core_code),
    .next_st_o(core_nst)
  );

  assign ready_o      = (fsm_q == IDLE);
  assign code_valid_o = busy;
  assign code_o       = busy ? core_code : 2'b00;
  assign sof_o        = (fsm_q == DATA) && (cnt_q == '0);
  assign eof_o        = (fsm_q == TAIL) && (cnt_q == CNT_ONE);

  always_comb begin
    fsm_d  = fsm_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    unique case (fsm_q)
      IDLE: begin
        if (valid_i) begin
          sreg_d = data_i;
          st_d   = 2'b00;
          cnt_d  = '0;
          fsm_d  = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
          st_d   = core_nst;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            fsm_d = TAIL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          st_d = core_nst;
          if (cnt_q == CNT_ONE) begin
            cnt_d = '0;
            fsm_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q  <= IDLE;
      sreg_q <= '0;
      cnt_q  <= '0;
      st_q   <= 2'b00;
    end else begin
      fsm_q  <= fsm_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
    end
  end

endmodule
